// File: rtl/periph_bus_pkg.sv
// Shared definitions for the peripheral register bus initiator:
// the FSM state encoding, the bus geometry and the device-select decoder.
package periph_bus_pkg;

    localparam int BUS_DATA_W = 32;
    localparam int BUS_LANES  = 4;
    localparam int MAX_NSEL   = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Out-of-range indices decode to an all-zero select so no device responds.
    function automatic logic [MAX_NSEL-1:0] onehot_sel(input int unsigned sel, input int unsigned nsel);
        logic [MAX_NSEL-1:0] vec;
        vec = '0;
        if (sel < nsel && sel < MAX_NSEL) begin
            vec = MAX_NSEL'(1) << sel;
        end
        return vec;
    endfunction

endpackage

// File: rtl/periph_bus_initiator_if.sv
// Request, response and device-side signals of the peripheral bus initiator.
// The master modport is the initiator's view; slave is the core/device environment.
interface periph_bus_initiator_if #(
    parameter int ADDR_W = 3,
    parameter int NSEL   = 4,
    parameter int SEL_W  = 3
);
    import periph_bus_pkg::*;

    logic                         i_req_valid;
    logic                         o_req_ready;
    logic                         i_req_we;
    logic [SEL_W-1:0]             i_req_sel;
    logic [ADDR_W-1:0]            i_req_addr;
    logic [BUS_DATA_W-1:0]        i_req_wdata;
    logic [BUS_LANES-1:0]         i_req_be;

    logic                         o_rsp_valid;
    logic                         i_rsp_ready;
    logic [BUS_DATA_W-1:0]        o_rsp_rdata;
    logic                         o_rsp_err;

    logic [NSEL-1:0]              o_bus_sel;
    logic [ADDR_W-1:0]            o_bus_addr;
    logic [BUS_DATA_W-1:0]        o_bus_dout;
    logic [BUS_LANES-1:0]         o_bus_wr_en;
    logic [NSEL*BUS_DATA_W-1:0]   i_bus_din;

    modport master (
        input  i_req_valid, i_req_we, i_req_sel, i_req_addr, i_req_wdata, i_req_be,
        output o_req_ready,
        output o_rsp_valid, o_rsp_rdata, o_rsp_err,
        input  i_rsp_ready,
        output o_bus_sel, o_bus_addr, o_bus_dout, o_bus_wr_en,
        input  i_bus_din
    );

    modport slave (
        output i_req_valid, i_req_we, i_req_sel, i_req_addr, i_req_wdata, i_req_be,
        input  o_req_ready,
        input  o_rsp_valid, o_rsp_rdata, o_rsp_err,
        output i_rsp_ready,
        input  o_bus_sel, o_bus_addr, o_bus_dout, o_bus_wr_en,
        output i_bus_din
    );

endinterface

// File: rtl/periph_rd_mux.sv
// Selects one device's 32-bit read word by index; indices with no device
// return zero data and raise out_of_range.
module periph_rd_mux
    import periph_bus_pkg::*;
#(
    parameter int NSEL  = 4,
    parameter int SEL_W = 3
) (
    input  logic [SEL_W-1:0]           sel,
    input  logic [NSEL*BUS_DATA_W-1:0] din,
    output logic [BUS_DATA_W-1:0]      data,
    output logic                       out_of_range
);

    always_comb begin
        data         = '0;
        out_of_range = 1'b1;
        for (int k = 0; k < NSEL; k++) begin
            if (sel == SEL_W'(k)) begin
                data         = din[k*BUS_DATA_W +: BUS_DATA_W];
                out_of_range = 1'b0;
            end
        end
    end

endmodule

// File: rtl/periph_bus_initiator.sv
// Single-outstanding initiator for the 32-bit peripheral register bus: a request is
// latched in IDLE, presented for one ACCESS cycle, held through WAIT for slow reads, then answered in RESP.
module periph_bus_initiator
    import periph_bus_pkg::*;
#(
    parameter int ADDR_W = 3,
    parameter int NSEL   = 4,
    parameter int SEL_W  = 3,
    parameter int RD_LAT = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    periph_bus_initiator_if.master bus
);

    localparam logic [2:0] WAIT_LOAD = (RD_LAT > 0) ? 3'(RD_LAT - 1) : 3'd0;

    state_t                state;
    state_t                state_next;

    logic                  req_we;
    logic [SEL_W-1:0]      req_sel;
    logic [ADDR_W-1:0]     req_addr;
    logic [BUS_DATA_W-1:0] req_wdata;
    logic [BUS_LANES-1:0]  req_be;
    logic [2:0]            wait_cnt;
    logic [BUS_DATA_W-1:0] rsp_rdata;
    logic                  rsp_err;

    logic                  accept;
    logic                  load_wait;
    logic                  dec_wait;
    logic                  capture_rsp;

    logic [BUS_DATA_W-1:0] mux_data;
    logic                  sel_oor;

    periph_rd_mux #(
        .NSEL  (NSEL),
        .SEL_W (SEL_W)
    ) u_rd_mux (
        .sel          (req_sel),
        .din          (bus.i_bus_din),
        .data         (mux_data),
        .out_of_range (sel_oor)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Writes finish straight after ACCESS; reads either sample at once or count down in WAIT.
    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        load_wait   = 1'b0;
        dec_wait    = 1'b0;
        capture_rsp = 1'b0;
        case (state)
            IDLE: begin
                if (bus.i_req_valid) begin
                    accept     = 1'b1;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (req_we || RD_LAT == 0) begin
                    capture_rsp = 1'b1;
                    state_next  = RESP;
                end else begin
                    load_wait  = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt == 3'd0) begin
                    capture_rsp = 1'b1;
                    state_next  = RESP;
                end else begin
                    dec_wait = 1'b1;
                end
            end
            RESP: begin
                if (bus.i_rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            req_we    <= 1'b0;
            req_sel   <= '0;
            req_addr  <= '0;
            req_wdata <= '0;
            req_be    <= '0;
            wait_cnt  <= 3'd0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                req_we    <= bus.i_req_we;
                req_sel   <= bus.i_req_sel;
                req_addr  <= bus.i_req_addr;
                req_wdata <= bus.i_req_wdata;
                req_be    <= bus.i_req_be;
            end
            if (load_wait) begin
                wait_cnt <= WAIT_LOAD;
            end else if (dec_wait) begin
                wait_cnt <= wait_cnt - 3'd1;
            end
            if (capture_rsp) begin
                rsp_rdata <= req_we ? '0 : mux_data;
                rsp_err   <= sel_oor;
            end
        end
    end

    // Reset forces every output low immediately, so a reset mid-transaction cannot leak a response.
    always_comb begin
        bus.o_req_ready = 1'b0;
        bus.o_rsp_valid = 1'b0;
        bus.o_rsp_rdata = '0;
        bus.o_rsp_err   = 1'b0;
        bus.o_bus_sel   = '0;
        bus.o_bus_addr  = '0;
        bus.o_bus_dout  = '0;
        bus.o_bus_wr_en = '0;
        if (!i_rst) begin
            case (state)
                IDLE: begin
                    bus.o_req_ready = 1'b1;
                end
                ACCESS: begin
                    bus.o_bus_sel   = NSEL'(onehot_sel(32'(req_sel), NSEL));
                    bus.o_bus_addr  = req_addr;
                    bus.o_bus_dout  = req_wdata;
                    bus.o_bus_wr_en = (req_we && !sel_oor) ? req_be : '0;
                end
                WAIT: begin
                    bus.o_bus_sel  = NSEL'(onehot_sel(32'(req_sel), NSEL));
                    bus.o_bus_addr = req_addr;
                    bus.o_bus_dout = req_wdata;
                end
                RESP: begin
                    bus.o_rsp_valid = 1'b1;
                    bus.o_rsp_rdata = rsp_rdata;
                    bus.o_rsp_err   = rsp_err;
                end
                default: ;
            endcase
        end
    end

endmodule
